regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between two requesters:
  - the in-order pipeline write-back (port A, fixed priority, no back-pressure);
  - a multi-cycle unit such as mult/div or load return (port B, valid/ready handshake).
- Keeps a 32-entry pending scoreboard for B destinations and flags RAW/WAW hazards to the decode stage.
- Sits between write-back and the register file, driving its write_address_i, write_data_i and ctrl_reg_write_i.

Parameters:
- STARVE_LIMIT, 8, consecutive cycles B may be refused before the arbiter forces a pipeline bubble.
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.

Ports:
- clk_i  input  1  single clock, rising edge.
- n_rst_i  input  1  asynchronous active-low reset.
- a_valid_i  input  1  pipeline write-back request.
- a_address_i  input  ADDR_W  pipeline destination.
- a_data_i  input  DATA_W  pipeline result.
- b_valid_i  input  1  multi-cycle unit request.
- b_address_i  input  ADDR_W  multi-cycle destination.
- b_data_i  input  DATA_W  multi-cycle result.
- b_ready_o  output  1  B accepted this cycle.
- issue_i  input  1  multi-cycle op issued this cycle.
- issue_address_i  input  ADDR_W  destination of the issued op.
- read_address1_i  input  ADDR_W  decode source 1.
- read_address2_i  input  ADDR_W  decode source 2.
- stall_o  output  1  decode must stall (hazard or forced bubble).
- write_address_o  output  ADDR_W  to register file.
- write_data_o  output  DATA_W  to register file.
- ctrl_reg_write_o  output  1  to register file.
- error_o  output  1  sticky protocol error.

Behaviour:
- Reset (n_rst_i low, async): all outputs 0, every scoreboard bit 0, starve counter 0, FSM in IDLE.
- Arbitration (combinational grant):
  - a_valid_i high: A wins.
  - otherwise b_ready_o = b_valid_i; b_ready_o is never high when a_valid_i is high.
- Write port: registered, one cycle of latency.
  - The winner's address and data appear on write_address_o/write_data_o the cycle after acceptance.
  - ctrl_reg_write_o is high for exactly that one cycle.
- Address 0: the handshake completes normally, but ctrl_reg_write_o stays 0 for that cycle.
- Scoreboard:
  - issue_i with a nonzero issue_address_i sets pending[addr] at the clock edge.
  - pending[addr] clears on the edge where ctrl_reg_write_o=1 commits a B write to addr.
  - Issue and B commit to the same address on the same edge: the set wins.
  - pending[0] is never set.
- stall_o is combinational and high if any of:
  - pending[read_address1_i] (RAW);
  - pending[read_address2_i] (RAW);
  - issue_i && pending[issue_address_i] (WAW);
  - FSM in FORCE.
  - Address 0 never stalls.
- FSM, three states:
  - IDLE: b_valid_i high and a_valid_i high → WAIT, counter=1. Otherwise stay.
  - WAIT:
    - B granted → IDLE, counter=0.
    - b_valid_i dropped → IDLE.
    - Refused again → counter+1.
    - counter==STARVE_LIMIT → FORCE.
  - FORCE: stall_o=1; B granted → IDLE.
    - a_valid_i high in FORCE: A still wins and error_o is set (sticky until reset).
- b_valid_i dropped while b_ready_o was low: not an error; the request is simply withdrawn.
- Reset mid-operation: any pending write is discarded, the scoreboard is cleared, and ctrl_reg_write_o drops immediately.

Decomposition:
- Shared package regfile_pkg:
  - ADDR_W, DATA_W, NUM_REGS=32, ZERO_REG=0;
  - arbiter state typedef {IDLE, WAIT, FORCE}.
- Sub-module regfile_scoreboard: 32 pending bits, set/clear ports, two read-hazard lookups plus a WAW lookup.
- The FSM, grant logic and write register stay in the top module.

Test Plan:
- A only, addr 3, data aaaaaaaa → next cycle write_address_o=3, write_data_o=aaaaaaaa, ctrl_reg_write_o=1 for one cycle; b_ready_o=0.
- A and B valid together (A: 4/55555555, B: 5/12345678), then A idle next cycle → A written first; B accepted on the second cycle and written on the third; scoreboard bit 5 clears on that edge.
- issue_i addr 6, then read_address1_i=6 → stall_o=1 until B writes 6/87654321; stall_o=0 the cycle after ctrl_reg_write_o pulses. A second issue to 6 while pending → stall_o=1 (WAW).
- a_valid_i held high for 8 cycles with B waiting (STARVE_LIMIT=8) → FSM reaches FORCE, stall_o=1. Bench drops a_valid_i → B granted, FSM returns to IDLE. Repeating with a_valid_i kept high in FORCE → error_o=1.
- B write to addr 0, data 11111111 → b_ready_o=1, ctrl_reg_write_o stays 0; issue to addr 0 never causes a stall.
- Assert n_rst_i low mid-WAIT with pending bits 1 and 2 set → all outputs and the scoreboard read 0 immediately; after release, read_address1_i=1 gives stall_o=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared widths, register-file constants and the write-port arbiter state type.
package regfile_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  localparam int ZERO_REG = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FORCE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard for multi-cycle destinations: one bit per register,
// with two read-hazard lookups and one write-after-write lookup.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              clk_i,
  input  logic              n_rst_i,
  input  logic              set_i,
  input  logic [ADDR_W-1:0] set_addr_i,
  input  logic              clr_i,
  input  logic [ADDR_W-1:0] clr_addr_i,
  input  logic [ADDR_W-1:0] rd1_addr_i,
  input  logic [ADDR_W-1:0] rd2_addr_i,
  input  logic [ADDR_W-1:0] waw_addr_i,
  output logic              rd1_hit_o,
  output logic              rd2_hit_o,
  output logic              waw_hit_o
);

  localparam int NUM = 2 ** ADDR_W;

  logic [NUM-1:0] pending_q;
  logic [NUM-1:0] pending_d;

  // Set is applied after clear so a same-edge issue keeps the bit pending;
  // the zero register is hardwired and never tracked.
  always_comb begin
    pending_d = pending_q;
    if (clr_i) pending_d[clr_addr_i] = 1'b0;
    if (set_i && (set_addr_i != ADDR_W'(ZERO_REG))) pending_d[set_addr_i] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) pending_q <= '0;
    else          pending_q <= pending_d;
  end

  assign rd1_hit_o = pending_q[rd1_addr_i];
  assign rd2_hit_o = pending_q[rd2_addr_i];
  assign waw_hit_o = pending_q[waw_addr_i];

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between pipeline write-back (A, fixed
// priority) and a multi-cycle unit (B, valid/ready), with starvation relief.
module regfile_write_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int ADDR_W       = regfile_pkg::ADDR_W,
  parameter int DATA_W       = regfile_pkg::DATA_W
) (
  input  logic              clk_i,
  input  logic              n_rst_i,
  input  logic              a_valid_i,
  input  logic [ADDR_W-1:0] a_address_i,
  input  logic [DATA_W-1:0] a_data_i,
  input  logic              b_valid_i,
  input  logic [ADDR_W-1:0] b_address_i,
  input  logic [DATA_W-1:0] b_data_i,
  output logic              b_ready_o,
  input  logic              issue_i,
  input  logic [ADDR_W-1:0] issue_address_i,
  input  logic [ADDR_W-1:0] read_address1_i,
  input  logic [ADDR_W-1:0] read_address2_i,
  output logic              stall_o,
  output logic [ADDR_W-1:0] write_address_o,
  output logic [DATA_W-1:0] write_data_o,
  output logic              ctrl_reg_write_o,
  output logic              error_o
);
  import regfile_pkg::*;

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              error_q, error_d;
  logic              wr_en_q, wr_en_d;
  logic              wr_from_b_q, wr_from_b_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic              b_grant;
  logic              rd1_hit, rd2_hit, waw_hit;

  // B is never granted while in reset so no handshake completes that would be lost.
  assign b_grant   = n_rst_i & b_valid_i & ~a_valid_i;
  assign b_ready_o = b_grant;

  always_comb begin
    wr_en_d     = 1'b0;
    wr_from_b_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    if (a_valid_i) begin
      wr_addr_d = a_address_i;
      wr_data_d = a_data_i;
      wr_en_d   = (a_address_i != ADDR_W'(ZERO_REG));
    end else if (b_grant) begin
      wr_addr_d   = b_address_i;
      wr_data_d   = b_data_i;
      wr_en_d     = (b_address_i != ADDR_W'(ZERO_REG));
      wr_from_b_d = 1'b1;
    end
  end

  // Starvation tracking: cnt counts consecutive refused B cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    error_d = error_q | ((state_q == FORCE) & a_valid_i);
    case (state_q)
      IDLE: begin
        if (b_valid_i && a_valid_i) begin
          cnt_d   = CNT_W'(1);
          state_d = (STARVE_LIMIT <= 1) ? FORCE : WAIT;
        end
      end
      WAIT: begin
        if (b_grant || !b_valid_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q + CNT_W'(1) == CNT_W'(STARVE_LIMIT)) state_d = FORCE;
        end
      end
      FORCE: begin
        if (b_grant || !b_valid_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      error_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_from_b_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      error_q     <= error_d;
      wr_en_q     <= wr_en_d;
      wr_from_b_q <= wr_from_b_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk_i      (clk_i),
    .n_rst_i    (n_rst_i),
    .set_i      (issue_i),
    .set_addr_i (issue_address_i),
    .clr_i      (wr_en_q & wr_from_b_q),
    .clr_addr_i (wr_addr_q),
    .rd1_addr_i (read_address1_i),
    .rd2_addr_i (read_address2_i),
    .waw_addr_i (issue_address_i),
    .rd1_hit_o  (rd1_hit),
    .rd2_hit_o  (rd2_hit),
    .waw_hit_o  (waw_hit)
  );

  assign stall_o          = rd1_hit | rd2_hit | (issue_i & waw_hit) | (state_q == FORCE);
  assign write_address_o  = wr_addr_q;
  assign write_data_o     = wr_data_q;
  assign ctrl_reg_write_o = wr_en_q;
  assign error_o          = error_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed and randomized checks of regfile_write_arbiter against a cycle-level
// behavioural model of the arbitration, scoreboard and starvation rules.
module tb_regfile_write_arbiter;

  localparam int LIMIT = 8;

  logic        clk_i = 1'b0;
  logic        n_rst_i;
  logic        a_valid_i, b_valid_i, issue_i;
  logic [4:0]  a_address_i, b_address_i, issue_address_i;
  logic [4:0]  read_address1_i, read_address2_i;
  logic [31:0] a_data_i, b_data_i;
  logic        b_ready_o, stall_o, ctrl_reg_write_o, error_o;
  logic [4:0]  write_address_o;
  logic [31:0] write_data_o;

  int checks = 0;
  int failures = 0;

  // Model state
  bit [31:0]   m_pend;
  bit          m_wr_en;
  bit          m_wr_b;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          m_streak;
  bit          m_forced;
  bit          m_err;

  regfile_write_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_W(5), .DATA_W(32)) dut (
    .clk_i(clk_i), .n_rst_i(n_rst_i),
    .a_valid_i(a_valid_i), .a_address_i(a_address_i), .a_data_i(a_data_i),
    .b_valid_i(b_valid_i), .b_address_i(b_address_i), .b_data_i(b_data_i),
    .b_ready_o(b_ready_o),
    .issue_i(issue_i), .issue_address_i(issue_address_i),
    .read_address1_i(read_address1_i), .read_address2_i(read_address2_i),
    .stall_o(stall_o),
    .write_address_o(write_address_o), .write_data_o(write_data_o),
    .ctrl_reg_write_o(ctrl_reg_write_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit av, input logic [4:0] aa, input logic [31:0] ad,
                       input bit bv, input logic [4:0] ba, input logic [31:0] bd,
                       input bit iv, input logic [4:0] ia,
                       input logic [4:0] r1, input logic [4:0] r2);
    a_valid_i = av; a_address_i = aa; a_data_i = ad;
    b_valid_i = bv; b_address_i = ba; b_data_i = bd;
    issue_i = iv; issue_address_i = ia;
    read_address1_i = r1; read_address2_i = r2;
  endtask

  task automatic model_reset();
    m_pend = '0; m_wr_en = 0; m_wr_b = 0; m_addr = '0; m_data = '0;
    m_streak = 0; m_forced = 0; m_err = 0;
  endtask

  // Entered at posedge+1 with inputs applied; returns at the next posedge+1.
  task automatic tick();
    bit exp_rdy, exp_stall;
    #3;
    exp_rdy   = b_valid_i && !a_valid_i;
    exp_stall = m_pend[read_address1_i] || m_pend[read_address2_i] ||
                (issue_i && m_pend[issue_address_i]) || m_forced;
    chk("b_ready", {31'd0, b_ready_o}, {31'd0, exp_rdy});
    chk("stall", {31'd0, stall_o}, {31'd0, exp_stall});
    @(posedge clk_i);
    if (m_wr_en && m_wr_b) m_pend[m_addr] = 1'b0;
    if (issue_i && issue_address_i != 0) m_pend[issue_address_i] = 1'b1;
    if (m_forced && a_valid_i) m_err = 1;
    if (a_valid_i) begin
      m_addr = a_address_i; m_data = a_data_i; m_wr_b = 0; m_wr_en = (a_address_i != 0);
    end else if (b_valid_i) begin
      m_addr = b_address_i; m_data = b_data_i; m_wr_b = 1; m_wr_en = (b_address_i != 0);
    end else begin
      m_wr_en = 0; m_wr_b = 0;
    end
    if (b_valid_i && a_valid_i) begin
      m_streak++;
      if (m_streak >= LIMIT) m_forced = 1;
    end else begin
      m_streak = 0; m_forced = 0;
    end
    #1;
    chk("ctrl_reg_write", {31'd0, ctrl_reg_write_o}, {31'd0, m_wr_en});
    chk("error", {31'd0, error_o}, {31'd0, m_err});
    if (m_wr_en) begin
      chk("write_address", {27'd0, write_address_o}, {27'd0, m_addr});
      chk("write_data", write_data_o, m_data);
    end
  endtask

  task automatic idle(input logic [4:0] r1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, r1, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_b_ready"}, {31'd0, b_ready_o}, 32'd0);
    chk({tag, "_stall"}, {31'd0, stall_o}, 32'd0);
    chk({tag, "_ctrl"}, {31'd0, ctrl_reg_write_o}, 32'd0);
    chk({tag, "_error"}, {31'd0, error_o}, 32'd0);
    chk({tag, "_waddr"}, {27'd0, write_address_o}, 32'd0);
    chk({tag, "_wdata"}, write_data_o, 32'd0);
  endtask

  initial begin
    n_rst_i = 1'b0;
    drive(0, 0, 0, 1, 5'd7, 32'h1, 0, 0, 0, 0);
    model_reset();
    #12;
    check_all_zero("reset");
    @(posedge clk_i); #1;
    idle(0);
    n_rst_i = 1'b1;

    // A only
    drive(1, 5'd3, 32'haaaaaaaa, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("a_only_data", write_data_o, 32'haaaaaaaa);
    idle(0); tick();

    // A and B together, B waits one cycle; bit 5 tracked
    drive(0, 0, 0, 0, 0, 0, 1, 5'd5, 0, 0); tick();
    drive(1, 5'd4, 32'h55555555, 1, 5'd5, 32'h12345678, 0, 0, 5'd5, 0); tick();
    drive(0, 0, 0, 1, 5'd5, 32'h12345678, 0, 0, 5'd5, 0); tick();
    idle(5'd5); tick();
    idle(5'd5); tick();

    // RAW on 6, then WAW on 6, then B writes 6
    drive(0, 0, 0, 0, 0, 0, 1, 5'd6, 0, 0); tick();
    idle(5'd6); tick();
    drive(0, 0, 0, 0, 0, 0, 1, 5'd6, 0, 5'd6); tick();
    drive(0, 0, 0, 1, 5'd6, 32'h87654321, 0, 0, 5'd6, 0); tick();
    idle(5'd6); tick();
    idle(5'd6); tick();

    // Starvation to FORCE, then release by dropping A
    for (int i = 0; i < LIMIT; i++) begin
      drive(1, 5'd9, 32'h100 + i, 1, 5'd10, 32'hbeef, 0, 0, 0, 0); tick();
    end
    drive(0, 0, 0, 1, 5'd10, 32'hbeef, 0, 0, 0, 0); tick();
    idle(0); tick();

    // Starvation again, A kept high in FORCE -> sticky error
    for (int i = 0; i < LIMIT + 2; i++) begin
      drive(1, 5'd11, 32'h200 + i, 1, 5'd12, 32'hcafe, 0, 0, 0, 0); tick();
    end
    drive(0, 0, 0, 1, 5'd12, 32'hcafe, 0, 0, 0, 0); tick();
    idle(0); tick();
    chk("error_sticky", {31'd0, error_o}, 32'd1);

    // Address 0: handshake without write; issue to 0 never stalls
    drive(0, 0, 0, 1, 5'd0, 32'h11111111, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0); tick();
    drive(0, 0, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0); tick();

    // Reset mid-WAIT with bits 1 and 2 pending
    drive(0, 0, 0, 0, 0, 0, 1, 5'd1, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 1, 5'd2, 0, 0); tick();
    drive(1, 5'd3, 32'h33, 1, 5'd1, 32'h44, 0, 0, 5'd1, 5'd2); tick();
    drive(1, 5'd3, 32'h34, 1, 5'd1, 32'h44, 0, 0, 5'd1, 5'd2);
    #2;
    n_rst_i = 1'b0;
    model_reset();
    #1;
    check_all_zero("midreset");
    @(posedge clk_i); #1;
    idle(5'd1);
    n_rst_i = 1'b1;
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 5'd1, 5'd2); tick();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 99) < 55, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 99) < 30, 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
